cpu_clk_ctrl: RTL and testbench

Run/step controller that sits directly downstream of the programmable clock divider.
- Consumes the divider's slow toggling output.
- Converts each rising edge of that output into a single-cycle clock-enable pulse for the MIPS core, gated by run/pause/single-step/halt control.
- Counts issued CPU cycles for the seven-segment display.

---
 rtl/cpu_ctrl_pkg.sv | 19 +
 rtl/btn_debounce.sv | 39 +++
 rtl/cpu_clk_ctrl.sv | 114 +++++++++++
 tb/tb_cpu_clk_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and defaults for the CPU run/step clock controller.
package cpu_ctrl_pkg;

  localparam logic [1:0] MODE_PAUSE  = 2'b00;
  localparam logic [1:0] MODE_RUN    = 2'b01;
  localparam logic [1:0] MODE_STEP   = 2'b10;
  localparam logic [1:0] MODE_HALTED = 2'b11;

  // 20 ms at 50 MHz
  localparam int DEBOUNCE_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    ST_PAUSE  = MODE_PAUSE,
    ST_RUN    = MODE_RUN,
    ST_STEP   = MODE_STEP,
    ST_HALTED = MODE_HALTED
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer: accepts a new level only after DEBOUNCE_CYCLES
// consecutive samples differ from the current level; pulses on 0->1.
module btn_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt == TC) begin
        level      <= raw;
        rise_pulse <= raw;
        cnt        <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/step controller: turns divider rising edges into single-cycle core
// enables under run/pause/step/halt control and counts issued cycles.
//
//   state  | meaning
//   PAUSE  | idle, waiting for sw_run or a step press
//   RUN    | free-run, one cpu_en per divider rising edge
//   STEP   | one step pending, fires on the next divider edge
//   HALTED | core requested halt, sticky until rst
module cpu_clk_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_clk,
  input  logic             btn_step,
  input  logic             sw_run,
  input  logic             halt,
  output logic             cpu_en,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] cycle_cnt
);

  logic   div_s1, div_s2, div_s3;
  logic   tick;
  logic   btn_s1, btn_s2;
  logic   btn_level, btn_rise;
  logic   step_req;
  state_t state, state_nxt;
  logic   en_nxt;

  // tick is registered so cpu_en lands three edges after div_clk is first sampled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_s1 <= 1'b0;
      div_s2 <= 1'b0;
      div_s3 <= 1'b0;
      tick   <= 1'b0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      div_s1 <= div_clk;
      div_s2 <= div_s1;
      div_s3 <= div_s2;
      tick   <= div_s2 & ~div_s3;
      btn_s1 <= btn_step;
      btn_s2 <= btn_s1;
    end
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk        (clk),
    .rst        (rst),
    .raw        (btn_s2),
    .level      (btn_level),
    .rise_pulse (btn_rise)
  );

  assign step_req = btn_rise & btn_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_PAUSE;
      cpu_en    <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state  <= state_nxt;
      cpu_en <= en_nxt;
      if (en_nxt) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    en_nxt    = 1'b0;
    if (halt) begin
      state_nxt = ST_HALTED;
    end else begin
      case (state)
        ST_PAUSE: begin
          if (sw_run) begin
            state_nxt = ST_RUN;
          end else if (step_req) begin
            state_nxt = ST_STEP;
          end
        end
        ST_RUN: begin
          if (!sw_run) begin
            state_nxt = ST_PAUSE;
          end else if (tick) begin
            en_nxt = 1'b1;
          end
        end
        ST_STEP: begin
          // further step presses are dropped while a step is pending
          if (tick) begin
            en_nxt    = 1'b1;
            state_nxt = ST_PAUSE;
          end
        end
        default: state_nxt = ST_HALTED;
      endcase
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed self-checking bench for cpu_clk_ctrl (DEBOUNCE_CYCLES=4, CNT_W=4,
// div_clk period 20 clk).
module tb_cpu_clk_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int DB = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          div_clk = 1'b0;
  logic          btn_step = 1'b0;
  logic          sw_run = 1'b0;
  logic          halt = 1'b0;
  logic          cpu_en;
  logic [1:0]    mode;
  logic [CW-1:0] cycle_cnt;

  int   compared = 0;
  int   mismatched = 0;
  int   en_seen = 0;
  int   dbl_seen = 0;
  int   base;
  logic en_prev = 1'b0;

  typedef struct {
    logic       run;
    logic       en;
    logic [1:0] md;
    logic [3:0] cnt;
  } vec_t;

  vec_t vt[20];

  cpu_clk_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .div_clk   (div_clk),
    .btn_step  (btn_step),
    .sw_run    (sw_run),
    .halt      (halt),
    .cpu_en    (cpu_en),
    .mode      (mode),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cpu_en) begin
      en_seen = en_seen + 1;
      if (en_prev) dbl_seen = dbl_seen + 1;
    end
    en_prev = cpu_en;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared = compared + 1;
    if (act !== exp) begin
      mismatched = mismatched + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  // One 20-clk divider period; checks cpu_en only at E+3 and its neighbours.
  task automatic div_cycle(input logic exp_en, input string name);
    div_clk = 1'b1;
    step(3);
    chk({name, " en@E+2"}, {31'd0, cpu_en}, 32'd0);
    step(1);
    chk({name, " en@E+3"}, {31'd0, cpu_en}, {31'd0, exp_en});
    step(1);
    chk({name, " en@E+4"}, {31'd0, cpu_en}, 32'd0);
    step(5);
    div_clk = 1'b0;
    step(10);
  endtask

  initial begin
    vt[0] = '{run: 1'b0, en: 1'b0, md: MODE_PAUSE, cnt: 4'd0};
    for (int i = 1; i <= 17; i++) vt[i] = '{run: 1'b1, en: 1'b1, md: MODE_RUN, cnt: 4'(i)};
    vt[18] = '{run: 1'b0, en: 1'b0, md: MODE_PAUSE, cnt: 4'd1};
    vt[19] = '{run: 1'b1, en: 1'b1, md: MODE_RUN, cnt: 4'd2};

    // reset state
    step(2);
    rst = 1'b0;
    step(1);
    chk("reset en", {31'd0, cpu_en}, 32'd0);
    chk("reset mode", {30'd0, mode}, {30'd0, MODE_PAUSE});
    chk("reset cnt", {28'd0, cycle_cnt}, 32'd0);

    // free-run and wrap, table driven
    do_reset();
    base = en_seen;
    for (int i = 0; i < 20; i++) begin
      sw_run = vt[i].run;
      div_cycle(vt[i].en, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d mode", i), {30'd0, mode}, {30'd0, vt[i].md});
      chk($sformatf("vec%0d cnt", i), {28'd0, cycle_cnt}, {28'd0, vt[i].cnt});
    end
    chk("table pulses", en_seen - base, 32'd18);

    // reset mid-operation with a pulse due
    do_reset();
    sw_run = 1'b1;
    div_cycle(1'b1, "pre-rst");
    div_clk = 1'b1;
    step(3);
    rst = 1'b1;
    #1;
    chk("midrst en", {31'd0, cpu_en}, 32'd0);
    chk("midrst mode", {30'd0, mode}, {30'd0, MODE_PAUSE});
    chk("midrst cnt", {28'd0, cycle_cnt}, 32'd0);
    sw_run = 1'b0;
    step(2);
    rst = 1'b0;
    base = en_seen;
    for (int i = 0; i < 5; i++) div_cycle(1'b0, "postrst");
    chk("postrst pulses", en_seen - base, 32'd0);
    chk("postrst mode", {30'd0, mode}, {30'd0, MODE_PAUSE});

    // single step with bouncy button, second press dropped
    do_reset();
    base = en_seen;
    btn_step = 1'b1; step(1);
    btn_step = 1'b0; step(1);
    btn_step = 1'b1; step(10);
    chk("step mode", {30'd0, mode}, {30'd0, MODE_STEP});
    btn_step = 1'b0; step(10);
    btn_step = 1'b1; step(10);
    btn_step = 1'b0; step(10);
    chk("step2 mode", {30'd0, mode}, {30'd0, MODE_STEP});
    chk("step2 no en", en_seen - base, 32'd0);
    div_cycle(1'b1, "step tick");
    chk("step done mode", {30'd0, mode}, {30'd0, MODE_PAUSE});
    chk("step done cnt", {28'd0, cycle_cnt}, 32'd1);
    div_cycle(1'b0, "step dropped");
    chk("step pulses", en_seen - base, 32'd1);
    chk("step final cnt", {28'd0, cycle_cnt}, 32'd1);

    // sw_run dropped coincident with tick
    do_reset();
    sw_run = 1'b1;
    div_cycle(1'b1, "run1");
    div_clk = 1'b1;
    step(3);
    sw_run = 1'b0;
    step(1);
    chk("runoff en", {31'd0, cpu_en}, 32'd0);
    chk("runoff mode", {30'd0, mode}, {30'd0, MODE_PAUSE});
    step(6);
    div_clk = 1'b0;
    step(10);
    chk("runoff cnt", {28'd0, cycle_cnt}, 32'd1);

    // halt coincident with tick, then sticky
    do_reset();
    sw_run = 1'b1;
    div_cycle(1'b1, "run2");
    div_clk = 1'b1;
    step(3);
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    chk("halt en", {31'd0, cpu_en}, 32'd0);
    chk("halt mode", {30'd0, mode}, {30'd0, MODE_HALTED});
    step(6);
    div_clk = 1'b0;
    step(10);
    base = en_seen;
    div_cycle(1'b0, "halted1");
    sw_run = 1'b0; step(3);
    btn_step = 1'b1; step(10);
    btn_step = 1'b0; step(10);
    sw_run = 1'b1;
    div_cycle(1'b0, "halted2");
    chk("halted pulses", en_seen - base, 32'd0);
    chk("halted mode", {30'd0, mode}, {30'd0, MODE_HALTED});
    chk("halted cnt", {28'd0, cycle_cnt}, 32'd1);
    sw_run = 1'b0;
    do_reset();
    chk("unhalt mode", {30'd0, mode}, {30'd0, MODE_PAUSE});

    // short glitch on the button is rejected
    do_reset();
    base = en_seen;
    btn_step = 1'b1; step(3);
    btn_step = 1'b0;
    for (int i = 0; i < 3; i++) div_cycle(1'b0, "glitch");
    chk("glitch mode", {30'd0, mode}, {30'd0, MODE_PAUSE});
    chk("glitch pulses", en_seen - base, 32'd0);

    chk("no back-to-back en", dbl_seen, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
